lfsr_stepper: RTL and testbench
===============================

Name: lfsr_stepper

Overview:
Parametrised LFSR engine, successor to the fixed 16-bit seed/shift LFSR.
- Loads a seed, then advances the register a programmable number of steps, up to STEPS_PER_CYC steps per clock.
- Signals completion with a one-cycle done pulse.
- Feeds scrambler/CRC-style consumers in the top-level datapath. Width, polynomial, seed and throughput are set per instance.

Parameters:
WIDTH, 16, register width in bits (2..64)
TAPS, 16'hB400, feedback tap mask over bits [WIDTH-1:0]; bit i set = d[i] taps feedback
SEED, 1, reset value of the register; must be non-zero
STEPS_PER_CYC, 1, LFSR steps applied per clock in RUN (1..8)
CNT_W, 8, width of step-count request

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
load  in  1  load seed_in into register (IDLE/DONE only)
seed_in  in  WIDTH  seed value
start  in  1  begin stepping nsteps steps
nsteps  in  CNT_W  number of single steps to perform
q  out  WIDTH  current register contents
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when stepping completes
zero_seed  out  1  sticky: a zero seed was loaded and replaced

Behaviour:
- Reset (rst low, async): d=SEED, state=IDLE, busy=0, done=0, zero_seed=0, remaining count=0.
- Single step (Fibonacci): fb = XOR-reduce(d & TAPS); d_next = {d[WIDTH-2:0], fb}.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1 -> d<=seed_in.
  - If seed_in==0: d<=1 and zero_seed<=1 (sticky until reset). Prevents lockup.
  - start=1 with nsteps>0 -> latch rem=nsteps, go RUN. busy rises the next cycle.
  - start=1 with nsteps==0 -> go DONE with no step; done pulses the next cycle.
  - load and start in the same cycle: load applies first; stepping begins from the new seed on the following cycle.
- RUN:
  - Each cycle apply k = min(rem, STEPS_PER_CYC) steps as a combinational chain; rem <= rem-k.
  - When rem reaches 0: go DONE.
  - Latency from start to done = ceil(nsteps/STEPS_PER_CYC)+1 cycles.
  - load and start are ignored in RUN; no queuing.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - start in DONE is ignored. load in DONE is honoured.
- q is d directly: registered, no extra latency.
- Reset asserted mid-RUN aborts immediately to the reset state. No done pulse is issued.
- Counter arithmetic is unsigned CNT_W bits; rem never underflows because k ≤ rem.

Optional Feature:
LFSR_GALOIS_EN
- Defined: Galois form per step. If d[WIDTH-1]=1 then d_next = (d<<1) ^ TAPS_G | 1, else d_next = d<<1. TAPS_G = TAPS shifted to the Galois-equivalent mask computed in the package function.
  - Same period; different sequence.
  - Reduced XOR depth for STEPS_PER_CYC>1.
- Undefined: Fibonacci form as above.
- Ports and FSM are identical in both builds.

Decomposition:
- Package lfsr_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE}
  - default tap constants per width (16'hB400, 32'h80200003 Galois, etc.)
  - function lfsr_step(d, taps) for one step, shared by RTL and bench model
- Sub-module lfsr_step_chain: combinational k-step unroll (k ≤ STEPS_PER_CYC), selected by remaining count.
- FSM and counter stay in lfsr_stepper.

Test Plan:
- Reset then idle 5 cycles -> q=0x0001, busy=0, done=0, zero_seed=0.
- Fibonacci default: load 0x0001, start nsteps=11 -> q=0x0801 at done. done is high exactly 1 cycle, 12 cycles after start.
- STEPS_PER_CYC=4, seed 0x0001, nsteps=11 -> q=0x0801. busy for 3 cycles (4+4+3 steps); done 4 cycles after start.
- Load seed 0x0000 -> q=0x0001, zero_seed=1; still 1 after a further load of 0x1234.
- start nsteps=0 -> q unchanged, done pulses next cycle. start with nsteps=20, then rst low mid-RUN -> q=SEED, busy=0, no done.
- WIDTH=16 full period from seed 0x0001 (nsteps sweeps totalling 65535) -> q returns to 0x0001 and no intermediate zero. Repeat with LFSR_GALOIS_EN defined.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and the single-step LFSR function.
// Define LFSR_GALOIS_EN to switch every step to the Galois form.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] TAPS_W8         = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_W16        = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_W32        = 64'h0000_0000_A300_0000;
  localparam logic [63:0] TAPS_W32_GALOIS = 64'h0000_0000_8020_0003;

  function automatic logic [63:0] width_mask(input int width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

  // Bit-reversing the Fibonacci mask gives the same characteristic polynomial
  // in Galois form, so both builds share the same period.
  function automatic logic [63:0] galois_taps(input logic [63:0] taps, input int width);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) g[width-1-i] = taps[i];
    end
    return g;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] d, input logic [63:0] taps,
                                            input int width);
    logic [63:0] m;
    logic [63:0] nxt;
    m = width_mask(width);
`ifdef LFSR_GALOIS_EN
    if (d[width-1]) nxt = ((d << 1) ^ galois_taps(taps, width)) | 64'd1;
    else            nxt = d << 1;
`else
    nxt = (d << 1) | {63'd0, ^(d & taps & m)};
`endif
    return nxt & m;
  endfunction

endpackage

// File: rtl/lfsr_step_chain.sv
// Combinational unroll of up to STEPS LFSR steps; k selects how many are applied.
module lfsr_step_chain
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [63:0] TAPS  = 64'hB400,
  parameter int          STEPS = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       k,
  output logic [WIDTH-1:0] d_next
);

  always_comb begin
    logic [WIDTH-1:0] stage;
    stage  = d;
    d_next = d;
    for (int i = 1; i <= STEPS; i++) begin
      stage = WIDTH'(lfsr_step(64'(stage), TAPS, WIDTH));
      if (4'(i) == k) d_next = stage;
    end
  end

endmodule

// File: rtl/lfsr_stepper.sv
// Seedable LFSR that advances a requested number of steps, up to STEPS_PER_CYC per clock.
// Build option: LFSR_GALOIS_EN selects Galois-form stepping (same ports and FSM).
module lfsr_stepper
  import lfsr_pkg::*;
#(
  parameter int          WIDTH         = 16,
  parameter logic [63:0] TAPS          = 64'hB400,
  parameter logic [63:0] SEED          = 64'd1,
  parameter int          STEPS_PER_CYC = 1,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] nsteps,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero_seed
);

  state_e           state;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_run;
  logic [CNT_W-1:0] rem;
  logic [3:0]       k;
  logic             seed_is_zero;
  logic [WIDTH-1:0] seed_val;

  // An all-zero seed would lock the register, so it is replaced by 1.
  assign seed_is_zero = (seed_in == '0);
  assign seed_val     = seed_is_zero ? WIDTH'(1) : seed_in;

  always_comb begin
    if (int'(rem) < STEPS_PER_CYC) k = 4'(rem);
    else                           k = 4'(STEPS_PER_CYC);
  end

  lfsr_step_chain #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS_PER_CYC)
  ) u_chain (
    .d      (d),
    .k      (k),
    .d_next (d_run)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      d         <= WIDTH'(SEED);
      rem       <= '0;
      zero_seed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            d <= seed_val;
            if (seed_is_zero) zero_seed <= 1'b1;
          end
          if (start) begin
            if (nsteps != '0) begin
              rem   <= nsteps;
              state <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          d   <= d_run;
          rem <= rem - CNT_W'(k);
          if (rem == CNT_W'(k)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (load) begin
            d <= seed_val;
            if (seed_is_zero) zero_seed <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign q    = d;
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_lfsr_stepper.sv
// Randomised self-checking bench: one- and four-step-per-clock instances share stimulus
// and are compared against a bit-level sequence model of the 16-bit LFSR.
module tb_lfsr_stepper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed_in = '0;
  logic [7:0]  nsteps = '0;

  logic [15:0] q1, q4;
  logic        busy1, busy4, done1, done4, zs1, zs4;

  int          assert_count = 0;
  int          fail_count = 0;
  logic [15:0] ref_q = 16'h0001;
  logic        ref_zero = 1'b0;
  bit          period_mon = 1'b0;
  int          zero_hits = 0;
  int          one_hits = 0;

`ifdef LFSR_GALOIS_EN
  localparam logic [15:0] EXP11 = 16'h0800;
`else
  localparam logic [15:0] EXP11 = 16'h0801;
`endif

  always #5 clk = ~clk;

  lfsr_stepper #(.WIDTH(16), .TAPS(64'hB400), .SEED(64'd1), .STEPS_PER_CYC(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .start(start), .nsteps(nsteps),
    .q(q1), .busy(busy1), .done(done1), .zero_seed(zs1)
  );

  lfsr_stepper #(.WIDTH(16), .TAPS(64'hB400), .SEED(64'd1), .STEPS_PER_CYC(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .start(start), .nsteps(nsteps),
    .q(q4), .busy(busy4), .done(done4), .zero_seed(zs4)
  );

  always @(negedge clk) begin
    if (period_mon) begin
      if (q1 == 16'h0000 || q4 == 16'h0000) zero_hits++;
      if (busy1 && q1 == 16'h0001) one_hits++;
    end
  end

  // Reference sequence: x^16+x^14+x^13+x^11+1 shifted in at bit 0, or its Galois twin.
  function automatic logic [15:0] refAdvance(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
`ifdef LFSR_GALOIS_EN
      v = v[15] ? (((v << 1) ^ 16'h002D) | 16'h0001) : (v << 1);
`else
      v = {v[14:0], ^(v & 16'hB400)};
`endif
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelLoad(input logic [15:0] sd);
    if (sd == 16'h0000) begin
      ref_q    = 16'h0001;
      ref_zero = 1'b1;
    end else begin
      ref_q = sd;
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge, returns on the next falling edge.
  task automatic applyStimulus(input logic ld, input logic [15:0] sd, input logic st,
                               input logic [7:0] n);
    load    = ld;
    seed_in = sd;
    start   = st;
    nsteps  = n;
    if (ld) modelLoad(sd);
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_q1"}, 64'(q1), 64'(ref_q));
    checkOutput({tag, "_q4"}, 64'(q4), 64'(ref_q));
    checkOutput({tag, "_zs1"}, 64'(zs1), 64'(ref_zero));
    checkOutput({tag, "_zs4"}, 64'(zs4), 64'(ref_zero));
  endtask

  task automatic runSteps(input logic [7:0] n, input logic ld, input logic [15:0] sd,
                          input bit inject);
    int cyc, lat1, lat4, dc1, dc4, bc1, bc4, budget;
    logic [15:0] qd1, qd4;
    budget = int'(n) + 8;
    lat1 = -1; lat4 = -1; dc1 = 0; dc4 = 0; bc1 = 0; bc4 = 0;
    qd1 = '0; qd4 = '0;
    applyStimulus(ld, sd, 1'b1, n);
    ref_q = refAdvance(ref_q, int'(n));
    cyc = 1;
    forever begin
      if (done1) begin dc1++; if (lat1 < 0) begin lat1 = cyc; qd1 = q1; end end
      if (done4) begin dc4++; if (lat4 < 0) begin lat4 = cyc; qd4 = q4; end end
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (inject && cyc == 1 && n != 8'd0) begin
        load    = 1'b1;
        start   = 1'b1;
        seed_in = 16'($urandom);
        nsteps  = 8'($urandom);
      end
      if ((lat1 >= 0 && lat4 >= 0 && cyc > lat1 && cyc > lat4) || cyc >= budget) break;
      @(negedge clk);
      load  = 1'b0;
      start = 1'b0;
      cyc++;
    end
    load  = 1'b0;
    start = 1'b0;
    checkOutput("lat1", 64'(lat1), 64'(int'(n) + 1));
    checkOutput("lat4", 64'(lat4), 64'((int'(n) + 3) / 4 + 1));
    checkOutput("donecnt1", 64'(dc1), 64'd1);
    checkOutput("donecnt4", 64'(dc4), 64'd1);
    checkOutput("busy1", 64'(bc1), 64'(n));
    checkOutput("busy4", 64'(bc4), 64'((int'(n) + 3) / 4));
    checkOutput("qdone1", 64'(qd1), 64'(ref_q));
    checkOutput("qdone4", 64'(qd4), 64'(ref_q));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] sd;
    int op;
    int dh;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkState("reset");
    checkOutput("reset_busy", 64'({busy1, busy4}), 64'd0);
    checkOutput("reset_done", 64'({done1, done4}), 64'd0);

    applyStimulus(1'b1, 16'h0001, 1'b0, 8'd0);
    runSteps(8'd11, 1'b0, 16'h0000, 1'b0);
    checkOutput("steps11_q1", 64'(q1), 64'(EXP11));
    checkOutput("steps11_q4", 64'(q4), 64'(EXP11));

    applyStimulus(1'b1, 16'h0000, 1'b0, 8'd0);
    checkOutput("zero_q", 64'(q1), 64'h0001);
    checkOutput("zero_flag", 64'(zs1), 64'd1);
    applyStimulus(1'b1, 16'h1234, 1'b0, 8'd0);
    checkOutput("zero_sticky_q", 64'(q1), 64'h1234);
    checkOutput("zero_sticky", 64'({zs1, zs4}), 64'd3);

    applyStimulus(1'b0, 16'h0000, 1'b1, 8'd0);
    checkOutput("n0_done", 64'({done1, done4}), 64'd3);
    checkOutput("n0_q", 64'(q1), 64'(ref_q));
    load = 1'b1; seed_in = 16'hBEEF; start = 1'b1; nsteps = 8'd5;
    modelLoad(16'hBEEF);
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checkState("doneload");
    checkOutput("doneload_done", 64'({done1, done4}), 64'd0);
    @(negedge clk);
    checkOutput("done_start_ignored", 64'({busy1, busy4}), 64'd0);

    runSteps(8'd9, 1'b1, 16'hACE1, 1'b0);

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      sd = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      case (op)
        0: begin
          applyStimulus(1'b1, sd, 1'b0, 8'd0);
          checkState("rnd_load");
        end
        1: runSteps(8'($urandom_range(0, 40)), 1'b0, 16'h0000, 1'b0);
        2: runSteps(8'($urandom_range(0, 40)), 1'b1, sd, 1'b0);
        default: runSteps(8'($urandom_range(1, 40)), 1'b0, 16'h0000, 1'b1);
      endcase
    end
    checkState("rnd_end");

    applyStimulus(1'b0, 16'h0000, 1'b1, 8'd20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_q = 16'h0001;
    ref_zero = 1'b0;
    #1;
    checkState("abort");
    checkOutput("abort_busy", 64'({busy1, busy4}), 64'd0);
    dh = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      if (done1 || done4) dh++;
    end
    checkOutput("abort_nodone", 64'(dh), 64'd0);
    checkState("abort_after");

    applyStimulus(1'b1, 16'h0001, 1'b0, 8'd0);
    zero_hits = 0;
    one_hits = 0;
    period_mon = 1'b1;
    repeat (257) runSteps(8'd255, 1'b0, 16'h0000, 1'b0);
    period_mon = 1'b0;
    checkOutput("period_q1", 64'(q1), 64'h0001);
    checkOutput("period_q4", 64'(q4), 64'h0001);
    checkOutput("period_nozero", 64'(zero_hits), 64'd0);
    checkOutput("period_once", 64'(one_hits), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
